// File: rtl/alert_scheduler.sv
// Round-robin scheduler sharing one registered alarm/alarm_bar stage among N latched alert sources.
// Each service holds the alarm for ON_CYCLES and is followed by a GAP_CYCLES quiet gap, then an idle cycle.
module alert_scheduler #(
   parameter int N          = 4,
   parameter int ON_CYCLES  = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic [N-1:0] clr,
   output logic         alarm,
   output logic         alarm_bar,
   output logic [N-1:0] grant,
   output logic [N-1:0] pending,
   output logic         busy
);

   localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int PW   = $clog2(N);
   localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
   localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] sel_q, sel_d;
   logic [N-1:0]  pending_q, pending_d;
   logic [N-1:0]  grant_q, grant_d;
   logic          alarm_q, alarm_d;
   logic          alarm_bar_q;
   logic          busy_q;

   logic          found;
   logic [PW-1:0] pick;
   logic          eos;
   int            idx;

   // First pending source at or after ptr, wrapping modulo N.
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_q) + k) % N;
         if (!found && pending_q[idx]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end
   end

   assign eos = (state_q == S_ON) && ((cnt_q == '0) || clr[sel_q]);

   always_comb begin
      for (int i = 0; i < N; i++) begin
         if (clr[i])                    pending_d[i] = 1'b0;
         else if (req[i])               pending_d[i] = 1'b1;
         else if (eos && grant_q[i])    pending_d[i] = 1'b0;
         else                           pending_d[i] = pending_q[i];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      alarm_d = alarm_q;
      case (state_q)
         S_IDLE: begin
            grant_d = '0;
            alarm_d = 1'b0;
            if (found) begin
               sel_d   = pick;
               grant_d = {{(N-1){1'b0}}, 1'b1} << pick;
               alarm_d = 1'b1;
               cnt_d   = ON_LOAD;
               state_d = S_ON;
            end
         end
         S_ON: begin
            if (eos) begin
               ptr_d   = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
               grant_d = '0;
               alarm_d = 1'b0;
               cnt_d   = GAP_LOAD;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_GAP: begin
            grant_d = '0;
            alarm_d = 1'b0;
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
            alarm_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ptr_q       <= '0;
         sel_q       <= '0;
         pending_q   <= '0;
         grant_q     <= '0;
         alarm_q     <= 1'b0;
         alarm_bar_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         sel_q       <= sel_d;
         pending_q   <= pending_d;
         grant_q     <= grant_d;
         alarm_q     <= alarm_d;
         alarm_bar_q <= ~alarm_d;
         busy_q      <= (state_d != S_IDLE);
      end
   end

   assign alarm     = alarm_q;
   assign alarm_bar = alarm_bar_q;
   assign grant     = grant_q;
   assign pending   = pending_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_alert_scheduler.sv
// Scenario bench for alert_scheduler: services are recorded by a monitor and matched against a queue of expected (grant, length) pairs.
module tb_alert_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] clr;
   logic       alarm, alarm_bar, busy;
   logic [3:0] grant, pending;

   typedef struct {
      logic [3:0] g;
      int         len;
   } exp_t;

   exp_t exp_q[$];
   int   rise_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   bit   mon_en = 0;
   logic prev_alarm = 1'b0;
   logic [3:0] cur_g;
   int   cur_len;

   always #5 clk = ~clk;

   alert_scheduler #(.N(4), .ON_CYCLES(8), .GAP_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req(req), .clr(clr),
      .alarm(alarm), .alarm_bar(alarm_bar), .grant(grant),
      .pending(pending), .busy(busy)
   );

   // Per-cycle invariants plus service extraction for the scoreboard.
   always @(negedge clk) begin
      cyc++;
      if (mon_en) begin
         tests++;
         if (alarm_bar !== ~alarm) begin
            fails++; $display("FAIL alarm_bar_inv: alarm=%b alarm_bar=%b", alarm, alarm_bar);
         end
         tests++;
         if (alarm !== (|grant) || !$onehot0(grant)) begin
            fails++; $display("FAIL grant_onehot: alarm=%b grant=%b", alarm, grant);
         end
         if (alarm === 1'b1 && prev_alarm !== 1'b1) begin
            cur_g = grant; cur_len = 1; rise_q.push_back(cyc);
         end else if (alarm === 1'b1) begin
            cur_len++;
            tests++;
            if (grant !== cur_g) begin
               fails++; $display("FAIL grant_stable: got %b want %b", grant, cur_g);
            end
         end else if (prev_alarm === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++; $display("FAIL unexpected_service: grant=%b len=%0d", cur_g, cur_len);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (cur_g !== e.g || cur_len != e.len) begin
                  fails++;
                  $display("FAIL service: got grant=%b len=%0d want grant=%b len=%0d", cur_g, cur_len, e.g, e.len);
               end
            end
         end
         prev_alarm = alarm;
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic push_exp(input logic [3:0] g, input int len);
      exp_t e;
      e.g = g; e.len = len;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; clr = '0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b1111; clr = '0;
      step(); step();
      tests++;
      if (alarm !== 1'b0 || alarm_bar !== 1'b1 || grant !== 4'b0 || pending !== 4'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: alarm=%b alarm_bar=%b grant=%b pending=%b busy=%b want 0 1 0000 0000 0",
                  alarm, alarm_bar, grant, pending, busy);
      end
      mon_en = 1;
      rst = 1'b0;
      step();
      tests++;
      if (pending !== 4'b1111) begin
         fails++; $display("FAIL reset_release_pending: got %b want 1111", pending);
      end
      rst = 1'b1; req = '0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      push_exp(4'b0100, 8);
      req = 4'b0100;
      step();
      req = '0;
      tests++;
      if (pending !== 4'b0100 || alarm !== 1'b0) begin
         fails++; $display("FAIL single_latch: pending=%b alarm=%b want 0100 0", pending, alarm);
      end
      step();
      tests++;
      if (alarm !== 1'b1 || grant !== 4'b0100 || busy !== 1'b1) begin
         fails++; $display("FAIL single_grant: alarm=%b grant=%b busy=%b want 1 0100 1", alarm, grant, busy);
      end
      for (int i = 0; i < 7; i++) step();
      tests++;
      if (alarm !== 1'b1) begin
         fails++; $display("FAIL single_on8: alarm=%b want 1", alarm);
      end
      step();
      tests++;
      if (alarm !== 1'b0 || busy !== 1'b1 || pending !== 4'b0) begin
         fails++; $display("FAIL single_gap1: alarm=%b busy=%b pending=%b want 0 1 0000", alarm, busy, pending);
      end
      step();
      tests++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL single_gap2: busy=%b want 1", busy);
      end
      step();
      tests++;
      if (busy !== 1'b0 || alarm !== 1'b0) begin
         fails++; $display("FAIL single_idle: busy=%b alarm=%b want 0 0", busy, alarm);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      rise_q.delete();
      push_exp(4'b0001, 8); push_exp(4'b0010, 8); push_exp(4'b1000, 8);
      push_exp(4'b0001, 8); push_exp(4'b0010, 8);
      req = 4'b1011;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
      tests++;
      if (exp_q.size() != 0) begin
         fails++; $display("FAIL rr_timeout: %0d services outstanding, want 0", exp_q.size());
         exp_q.delete();
      end
      tests++;
      if (rise_q.size() < 5) begin
         fails++; $display("FAIL rr_rises: got %0d want 5", rise_q.size());
      end else begin
         for (int i = 1; i < 5; i++) begin
            tests++;
            if (rise_q[i] - rise_q[i-1] != 11) begin
               fails++; $display("FAIL rr_period: got %0d want 11", rise_q[i] - rise_q[i-1]);
            end
         end
      end
      req = '0; clr = 4'b1111;
      step();
      clr = '0;
      for (int i = 0; i < 4; i++) step();
      tests++;
      if (busy !== 1'b0 || pending !== 4'b0) begin
         fails++; $display("FAIL rr_drain: busy=%b pending=%b want 0 0000", busy, pending);
      end
   endtask

   task automatic test_abort();
      do_reset();
      push_exp(4'b0010, 3);
      req = 4'b0010;
      step();
      req = '0;
      step(); step(); step();
      clr = 4'b0010;
      step();
      clr = '0;
      tests++;
      if (alarm !== 1'b0 || pending !== 4'b0 || busy !== 1'b1) begin
         fails++; $display("FAIL abort_exit: alarm=%b pending=%b busy=%b want 0 0000 1", alarm, pending, busy);
      end
      step();
      tests++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL abort_gap2: busy=%b want 1", busy);
      end
      step();
      tests++;
      if (busy !== 1'b0) begin
         fails++; $display("FAIL abort_idle: busy=%b want 0", busy);
      end
      // Pointer moved past source 1, so source 2 is served before source 0.
      push_exp(4'b0100, 8); push_exp(4'b0001, 8);
      req = 4'b0101;
      step();
      req = '0;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
      tests++;
      if (exp_q.size() != 0) begin
         fails++; $display("FAIL abort_ptr_timeout: %0d outstanding, want 0", exp_q.size());
         exp_q.delete();
      end
      for (int i = 0; i < 4; i++) step();
   endtask

   task automatic test_conflicts();
      do_reset();
      req = 4'b0001; clr = 4'b0001;
      step();
      tests++;
      if (pending !== 4'b0) begin
         fails++; $display("FAIL conflict_clr_wins: pending=%b want 0000", pending);
      end
      req = '0; clr = '0;
      step(); step();
      tests++;
      if (alarm !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL conflict_no_service: alarm=%b busy=%b want 0 0", alarm, busy);
      end
      push_exp(4'b0010, 8);
      req = 4'b0010;
      step();
      req = '0;
      step();
      tests++;
      if (grant !== 4'b0010) begin
         fails++; $display("FAIL conflict_grant: got %b want 0010", grant);
      end
      req = 4'b1000;
      step();
      req = '0;
      tests++;
      if (pending !== 4'b1010) begin
         fails++; $display("FAIL conflict_latch3: got %b want 1010", pending);
      end
      clr = 4'b1000;
      step();
      clr = '0;
      tests++;
      if (pending !== 4'b0010 || grant !== 4'b0010 || alarm !== 1'b1) begin
         fails++; $display("FAIL conflict_clr3: pending=%b grant=%b alarm=%b want 0010 0010 1", pending, grant, alarm);
      end
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
      tests++;
      if (exp_q.size() != 0) begin
         fails++; $display("FAIL conflict_timeout: %0d outstanding, want 0", exp_q.size());
         exp_q.delete();
      end
      for (int i = 0; i < 5; i++) step();
      tests++;
      if (busy !== 1'b0 || pending !== 4'b0) begin
         fails++; $display("FAIL conflict_after: busy=%b pending=%b want 0 0000", busy, pending);
      end
   endtask

   task automatic test_reset_mid_on();
      do_reset();
      push_exp(4'b0010, 5);
      req = 4'b0110;
      step(); step();
      tests++;
      if (grant !== 4'b0010) begin
         fails++; $display("FAIL rstmid_grant: got %b want 0010", grant);
      end
      for (int i = 0; i < 4; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests++;
      if (alarm !== 1'b0 || alarm_bar !== 1'b1 || grant !== 4'b0 || pending !== 4'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_state: alarm=%b alarm_bar=%b grant=%b pending=%b busy=%b want 0 1 0000 0000 0",
                  alarm, alarm_bar, grant, pending, busy);
      end
      push_exp(4'b0010, 8);
      step(); step();
      tests++;
      if (grant !== 4'b0010 || alarm !== 1'b1) begin
         fails++; $display("FAIL rstmid_restart: grant=%b alarm=%b want 0010 1", grant, alarm);
      end
      req = '0; clr = 4'b0100;
      step();
      clr = '0;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
      tests++;
      if (exp_q.size() != 0) begin
         fails++; $display("FAIL rstmid_timeout: %0d outstanding, want 0", exp_q.size());
         exp_q.delete();
      end
      for (int i = 0; i < 4; i++) step();
   endtask

   initial begin
      rst = 1'b1; req = '0; clr = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_abort();
      test_conflicts();
      test_reset_mid_on();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
